// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: writeback and forward
// select encodings, the in-flight destination tag and its match rule.
package hazard_pkg;

    localparam int TAG_RW = 5;

    typedef enum logic [1:0] {
        WB_LOAD = 2'd0,
        WB_ALU  = 2'd1,
        WB_PC   = 2'd2
    } wbsel_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_PC  = 2'd3
    } fwdsel_e;

    typedef struct packed {
        logic              valid;
        logic [TAG_RW-1:0] rd;
        logic              regwen;
        wbsel_e            wbsel;
    } tag_t;

    localparam tag_t TAG_INVALID = '{valid: 1'b0, rd: '0, regwen: 1'b0, wbsel: WB_LOAD};

    // x0 is hardwired to zero, so a write to it never produces a forwardable value.
    function automatic logic tag_hit(input tag_t t, input logic [TAG_RW-1:0] rs,
                                     input logic use_rs);
        return t.valid && t.regwen && (t.rd == rs) && (rs != '0) && use_rs;
    endfunction

endpackage

// File: rtl/fwd_pick.sv
// Per-operand forwarding decision for the instruction in ID, looking at the
// producers currently in the EX and MEM tag slots.
module fwd_pick
    import hazard_pkg::*;
(
    input  logic [TAG_RW-1:0] i_rs,
    input  logic              i_use,
    input  tag_t              i_ex_tag,
    input  tag_t              i_mem_tag,
    output fwdsel_e           o_fwdsel,
    output logic              o_pcsel,
    output logic              o_load_hazard
);

    logic w_hit_ex;
    logic w_hit_mem;

    assign w_hit_ex  = tag_hit(i_ex_tag, i_rs, i_use);
    assign w_hit_mem = tag_hit(i_mem_tag, i_rs, i_use);

    // The EX-slot producer is the youngest writer, so it shadows the MEM slot.
    always_comb begin
        o_fwdsel      = FWD_REG;
        o_pcsel       = 1'b0;
        o_load_hazard = 1'b0;
        if (w_hit_ex) begin
            case (i_ex_tag.wbsel)
                WB_ALU:  o_fwdsel = FWD_MEM;
                WB_PC:   o_fwdsel = FWD_PC;
                WB_LOAD: o_load_hazard = 1'b1;
                default: o_fwdsel = FWD_REG;
            endcase
        end else if (w_hit_mem) begin
            if (i_mem_tag.wbsel == WB_PC) begin
                o_fwdsel = FWD_PC;
                o_pcsel  = 1'b1;
            end else begin
                o_fwdsel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB destination tags, produces
// registered EX forwarding selects and combinational stall/flush/bubble controls.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = TAG_RW,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwen,
    input  logic [1:0]       id_wbsel,
    input  logic             ex_redirect,
    output logic [1:0]       fwdselA,
    output logic [1:0]       fwdselB,
    output logic             pcselA,
    output logic             pcselB,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_id,
    output logic             bubble_ex,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    tag_t             r_ex_tag;
    tag_t             r_mem_tag;
    tag_t             r_wb_tag;
    fwdsel_e          r_fwdsel_a;
    fwdsel_e          r_fwdsel_b;
    logic             r_pcsel_a;
    logic             r_pcsel_b;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    tag_t    w_id_tag;
    fwdsel_e w_fwdsel_a;
    fwdsel_e w_fwdsel_b;
    logic    w_pcsel_a;
    logic    w_pcsel_b;
    logic    w_haz_a;
    logic    w_haz_b;
    logic    w_load_use;
    logic    w_stall;
    logic    w_bubble;

    assign w_id_tag = '{valid: id_valid, rd: id_rd, regwen: id_regwen, wbsel: wbsel_e'(id_wbsel)};

    fwd_pick u_pick_a (
        .i_rs          (id_rs1),
        .i_use         (id_use_rs1),
        .i_ex_tag      (r_ex_tag),
        .i_mem_tag     (r_mem_tag),
        .o_fwdsel      (w_fwdsel_a),
        .o_pcsel       (w_pcsel_a),
        .o_load_hazard (w_haz_a)
    );

    fwd_pick u_pick_b (
        .i_rs          (id_rs2),
        .i_use         (id_use_rs2),
        .i_ex_tag      (r_ex_tag),
        .i_mem_tag     (r_mem_tag),
        .o_fwdsel      (w_fwdsel_b),
        .o_pcsel       (w_pcsel_b),
        .o_load_hazard (w_haz_b)
    );

    // Controls are held quiet while rst is asserted; a redirect overrides any stall.
    assign w_load_use = ~rst & id_valid & (w_haz_a | w_haz_b);
    assign w_stall    = w_load_use & ~ex_redirect;
    assign w_bubble   = ~rst & (ex_redirect | w_load_use | ~id_valid);

    assign stall_if  = w_stall;
    assign stall_id  = w_stall;
    assign flush_id  = ~rst & ex_redirect;
    assign bubble_ex = w_bubble;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_tag      <= TAG_INVALID;
            r_mem_tag     <= TAG_INVALID;
            r_wb_tag      <= TAG_INVALID;
            r_fwdsel_a    <= FWD_REG;
            r_fwdsel_b    <= FWD_REG;
            r_pcsel_a     <= 1'b0;
            r_pcsel_b     <= 1'b0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_wb_tag  <= r_mem_tag;
            r_mem_tag <= r_ex_tag;
            r_ex_tag  <= w_bubble ? TAG_INVALID : w_id_tag;
            if (w_bubble) begin
                r_fwdsel_a <= FWD_REG;
                r_fwdsel_b <= FWD_REG;
                r_pcsel_a  <= 1'b0;
                r_pcsel_b  <= 1'b0;
            end else begin
                r_fwdsel_a <= w_fwdsel_a;
                r_fwdsel_b <= w_fwdsel_b;
                r_pcsel_a  <= w_pcsel_a;
                r_pcsel_b  <= w_pcsel_b;
            end
            if (w_stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
            if (ex_redirect && (r_flush_count != '1))
                r_flush_count <= r_flush_count + 1'b1;
        end
    end

    assign fwdselA     = r_fwdsel_a;
    assign fwdselB     = r_fwdsel_b;
    assign pcselA      = r_pcsel_a;
    assign pcselB      = r_pcsel_b;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

    // The WB slot is never forwarded from (write-first register file); it is
    // kept for pipeline bookkeeping and must come out of reset empty.
    a_wb_clear: assert property (@(posedge clk) rst |=> (r_wb_tag == TAG_INVALID));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed pipeline scenarios plus random
// instruction streams checked against an in-flight history model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_regwen = 1'b0;
    logic [1:0]  id_wbsel = 2'd1;
    logic        ex_redirect = 1'b0;
    logic [1:0]  fwdselA, fwdselB;
    logic        pcselA, pcselB, stall_if, stall_id, flush_id, bubble_ex;
    logic [31:0] stall_count, flush_count;

    int vectors = 0;
    int miscompares = 0;

    // History of issued instructions: index 0 issued one cycle ago, 1 two ago, 2 three ago.
    logic        h_v[3];
    logic [4:0]  h_rd[3];
    logic        h_wen[3];
    logic [1:0]  h_wb[3];
    logic [1:0]  e_fa, e_fb;
    logic        e_pa, e_pb;
    logic [31:0] e_sc, e_fc;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwen(id_regwen), .id_wbsel(id_wbsel), .ex_redirect(ex_redirect),
        .fwdselA(fwdselA), .fwdselB(fwdselB), .pcselA(pcselA), .pcselB(pcselB),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .bubble_ex(bubble_ex), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            h_v[i] = 1'b0; h_rd[i] = '0; h_wen[i] = 1'b0; h_wb[i] = 2'd0;
        end
        e_fa = 2'd0; e_fb = 2'd0; e_pa = 1'b0; e_pb = 1'b0; e_sc = '0; e_fc = '0;
    endtask

    // Youngest real writer of rs wins; distance 1 lands in MEM, distance 2 in WB.
    function automatic void decide(input logic use_rs, input logic [4:0] rs,
                                   output logic [1:0] sel, output logic pc, output logic haz);
        logic found;
        sel = 2'd0; pc = 1'b0; haz = 1'b0; found = 1'b0;
        if (use_rs && rs != 5'd0) begin
            for (int d = 0; d < 2; d++) begin
                if (!found && h_v[d] && h_wen[d] && h_rd[d] == rs) begin
                    found = 1'b1;
                    if (d == 0) begin
                        if (h_wb[d] == 2'd0) haz = 1'b1;
                        else if (h_wb[d] == 2'd1) sel = 2'd2;
                        else if (h_wb[d] == 2'd2) sel = 2'd3;
                    end else begin
                        if (h_wb[d] == 2'd2) begin sel = 2'd3; pc = 1'b1; end
                        else sel = 2'd1;
                    end
                end
            end
        end
    endfunction

    // Entered at posedge+1; leaves at the following posedge+1.
    task automatic drive_cycle(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic wen, input logic [1:0] wb, input logic redir);
        logic [1:0] sa, sb;
        logic pa, pb, ha, hb, lu, x_stall, x_bub;
        id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_regwen = wen; id_wbsel = wb; ex_redirect = redir;
        decide(u1, rs1, sa, pa, ha);
        decide(u2, rs2, sb, pb, hb);
        lu = v & (ha | hb);
        x_stall = lu & ~redir;
        x_bub = redir | lu | ~v;
        @(negedge clk);
        vectors++;
        if ({stall_if, stall_id, flush_id, bubble_ex} !== {x_stall, x_stall, redir, x_bub}) begin
            miscompares++;
            $display("FAIL ctl(if,id,flush,bub) t=%0t: got %b want %b", $time,
                     {stall_if, stall_id, flush_id, bubble_ex}, {x_stall, x_stall, redir, x_bub});
        end
        if (x_stall && e_sc != 32'hFFFF_FFFF) e_sc = e_sc + 32'd1;
        if (redir && e_fc != 32'hFFFF_FFFF) e_fc = e_fc + 32'd1;
        if (x_bub) begin e_fa = 2'd0; e_fb = 2'd0; e_pa = 1'b0; e_pb = 1'b0; end
        else begin e_fa = sa; e_fb = sb; e_pa = pa; e_pb = pb; end
        for (int i = 2; i > 0; i--) begin
            h_v[i] = h_v[i-1]; h_rd[i] = h_rd[i-1]; h_wen[i] = h_wen[i-1]; h_wb[i] = h_wb[i-1];
        end
        h_v[0] = v & ~x_bub; h_rd[0] = rd; h_wen[0] = wen; h_wb[0] = wb;
        @(posedge clk); #1;
        vectors++;
        if ({fwdselA, pcselA, fwdselB, pcselB} !== {e_fa, e_pa, e_fb, e_pb}) begin
            miscompares++;
            $display("FAIL sel(fA,pA,fB,pB) t=%0t: got %b want %b", $time,
                     {fwdselA, pcselA, fwdselB, pcselB}, {e_fa, e_pa, e_fb, e_pb});
        end
        vectors++;
        if (stall_count !== e_sc || flush_count !== e_fc) begin
            miscompares++;
            $display("FAIL counters t=%0t: got stall=%0h flush=%0h want stall=%0h flush=%0h",
                     $time, stall_count, flush_count, e_sc, e_fc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; id_valid = 1'b1; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_redirect = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; id_valid = 1'b0; ex_redirect = 1'b1; id_use_rs1 = 1'b1; id_rs1 = 5'd3;
        @(negedge clk);
        vectors++;
        if ({stall_if, stall_id, flush_id, bubble_ex} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 0000", {stall_if, stall_id, flush_id, bubble_ex});
        end
        @(posedge clk); #1;
        vectors++;
        if ({fwdselA, fwdselB, pcselA, pcselB} !== 6'd0 || stall_count !== 32'd0 || flush_count !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_regs: got sel=%b sc=%0h fc=%0h want zeros",
                     {fwdselA, fwdselB, pcselA, pcselB}, stall_count, flush_count);
        end
        ex_redirect = 1'b0;
        do_reset();
    endtask

    task automatic test_alu_chain();
        do_reset();
        drive_cycle(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 2'd1, 0);
        drive_cycle(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 2'd1, 0);
        vectors++;
        if (fwdselA !== 2'b10 || pcselA !== 1'b0 || stall_count !== 32'd0) begin
            miscompares++;
            $display("FAIL alu_chain: got fA=%b pA=%b sc=%0d want 10 0 0", fwdselA, pcselA, stall_count);
        end
    endtask

    task automatic test_one_gap();
        do_reset();
        drive_cycle(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 2'd1, 0);
        drive_cycle(1, 5'd3, 1, 5'd4, 1, 5'd9, 1, 2'd1, 0);
        drive_cycle(1, 5'd2, 1, 5'd5, 1, 5'd6, 1, 2'd1, 0);
        vectors++;
        if (fwdselB !== 2'b01 || fwdselA !== 2'b00) begin
            miscompares++;
            $display("FAIL one_gap: got fA=%b fB=%b want 00 01", fwdselA, fwdselB);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_cycle(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 2'd0, 0);
        drive_cycle(1, 5'd7, 1, 5'd2, 1, 5'd8, 1, 2'd1, 0);
        vectors++;
        if (fwdselA !== 2'b00 || stall_count !== 32'd1) begin
            miscompares++;
            $display("FAIL load_use_bubble: got fA=%b sc=%0d want 00 1", fwdselA, stall_count);
        end
        drive_cycle(1, 5'd7, 1, 5'd2, 1, 5'd8, 1, 2'd1, 0);
        vectors++;
        if (fwdselA !== 2'b01 || stall_count !== 32'd1) begin
            miscompares++;
            $display("FAIL load_use_fwd: got fA=%b sc=%0d want 01 1", fwdselA, stall_count);
        end
    endtask

    task automatic test_pc_fwd();
        do_reset();
        drive_cycle(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 2'd2, 0);
        drive_cycle(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 2'd1, 0);
        vectors++;
        if (fwdselA !== 2'b11 || pcselA !== 1'b0) begin
            miscompares++;
            $display("FAIL pc_fwd_mem: got fA=%b pA=%b want 11 0", fwdselA, pcselA);
        end
        do_reset();
        drive_cycle(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 2'd2, 0);
        drive_cycle(1, 5'd4, 1, 5'd5, 1, 5'd6, 1, 2'd1, 0);
        drive_cycle(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 2'd1, 0);
        vectors++;
        if (fwdselA !== 2'b11 || pcselA !== 1'b1) begin
            miscompares++;
            $display("FAIL pc_fwd_wb: got fA=%b pA=%b want 11 1", fwdselA, pcselA);
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        drive_cycle(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 2'd0, 0);
        drive_cycle(1, 5'd7, 1, 5'd2, 1, 5'd8, 1, 2'd1, 1);
        vectors++;
        if (flush_count !== 32'd1 || stall_count !== 32'd0 || fwdselA !== 2'b00) begin
            miscompares++;
            $display("FAIL redirect_stall: got fc=%0d sc=%0d fA=%b want 1 0 00",
                     flush_count, stall_count, fwdselA);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive_cycle(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 2'd1, 0);
        drive_cycle(1, 5'd0, 1, 5'd0, 1, 5'd4, 1, 2'd1, 0);
        vectors++;
        if (fwdselA !== 2'b00 || fwdselB !== 2'b00) begin
            miscompares++;
            $display("FAIL zero_reg: got fA=%b fB=%b want 00 00", fwdselA, fwdselB);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.r_stall_count = 32'hFFFF_FFFE;
        #1 release dut.r_stall_count;
        e_sc = 32'hFFFF_FFFE;
        for (int k = 0; k < 2; k++) begin
            drive_cycle(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 2'd0, 0);
            drive_cycle(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 2'd1, 0);
            drive_cycle(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 2'd1, 0);
        end
        vectors++;
        if (stall_count !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL stall_saturate: got %0h want ffffffff", stall_count);
        end
    endtask

    task automatic test_rst_mid_stall();
        do_reset();
        drive_cycle(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 2'd0, 0);
        drive_cycle(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 2'd1, 0);
        drive_cycle(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 2'd0, 0);
        id_rs1 = 5'd7; id_use_rs1 = 1'b1; id_rd = 5'd8; id_wbsel = 2'd1; ex_redirect = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({stall_if, stall_id, flush_id, bubble_ex} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_mid_stall_ctl: got %b want 0000", {stall_if, stall_id, flush_id, bubble_ex});
        end
        @(posedge clk); #1;
        vectors++;
        if ({fwdselA, fwdselB, pcselA, pcselB, stall_if, stall_id, flush_id, bubble_ex} !== 10'd0 ||
            stall_count !== 32'd0 || flush_count !== 32'd0) begin
            miscompares++;
            $display("FAIL rst_mid_stall_out: got sel=%b sc=%0h fc=%0h want zeros",
                     {fwdselA, fwdselB, pcselA, pcselB}, stall_count, flush_count);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            drive_cycle($urandom_range(0, 99) < 88,
                        5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 4)), $urandom_range(0, 99) < 75,
                        2'($urandom_range(0, 2)), $urandom_range(0, 99) < 10);
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_alu_chain();
        test_one_gap();
        test_load_use();
        test_pc_fwd();
        test_redirect_stall();
        test_zero_reg();
        test_saturation();
        test_rst_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and forwarding controller that produces the operand-forwarding selects consumed by the EX stage (fwdselA/B, pcselA/B). It also produces stall, flush and bubble controls for IF/ID/EX. It tracks in-flight destination tags for the EX, MEM and WB slots and decides forwarding while an instruction is in ID. The selects are registered so they line up with that instruction's EX cycle.

Parameters:
REG_W, 5, register-index width
CNT_W, 32, width of the stall/flush performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_W  source register 1 index
id_rs2  in  REG_W  source register 2 index
id_use_rs1  in  1  instruction reads rs1
id_use_rs2  in  1  instruction reads rs2
id_rd  in  REG_W  destination index
id_regwen  in  1  instruction writes rd
id_wbsel  in  2  writeback source: 0 load data, 1 ALU result, 2 PC+4
ex_redirect  in  1  EX resolved a taken branch or jump this cycle
fwdselA  out  2  EX operand-A select: 00 reg, 01 wdata, 10 res_mem, 11 PC path
fwdselB  out  2  same encoding for operand B
pcselA  out  1  PC-path source for A: 0 pc_mem, 1 pc_wb
pcselB  out  1  same for B
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
flush_id  out  1  clear IF/ID register
bubble_ex  out  1  load a NOP into ID/EX
stall_count  out  CNT_W  cycles stalled, saturating
flush_count  out  CNT_W  redirects seen, saturating

Behaviour:
- Reset:
  - all tags invalid; fwdselA/B=00; pcselA/B=0; counters=0.
  - stall_if, stall_id, flush_id and bubble_ex are 0 during and after reset until a hazard occurs.
- Tag pipeline: each tag holds {valid, rd, regwen, wbsel}, stored as ex_tag, mem_tag and wb_tag. Every cycle:
  - wb_tag <= mem_tag
  - mem_tag <= ex_tag
  - ex_tag <= bubble_ex ? invalid : ID tag
- A tag "matches" source rs when: valid & regwen & rd==rs & rs!=0 & use_rsX.
- Per-operand decision, evaluated combinationally in ID:
  - No match, or rs==0: 00.
  - ex_tag match (producer will be in MEM during consumer's EX):
    - wbsel ALU -> 10
    - wbsel PC -> 11 with pcsel=0
    - wbsel load -> load-use hazard, no forward
  - Otherwise mem_tag match (producer will be in WB):
    - wbsel PC -> 11 with pcsel=1
    - else -> 01
  - ex_tag has priority over mem_tag.
  - wb_tag needs no forward: the register file is write-first, so a same-cycle read returns the written value.
- Load-use hazard:
  - Combinational: stall_if=stall_id=bubble_ex=1.
  - Lasts exactly one cycle. Next cycle the load sits in mem_tag and selects 01.
- Redirect: ex_redirect=1 gives flush_id=1 and bubble_ex=1, both combinational.
  - Redirect has priority over a stall: stall_if/stall_id are forced to 0 in that cycle.
- id_valid=0 gives bubble_ex=1 with no stall.
- Registered selects: on each clk, fwdsel/pcsel are updated with the ID decision. When bubble_ex=1 they are loaded with 00/0 instead. Latency is exactly 1 cycle, from ID decision to EX use.
- Counters:
  - stall_count increments in each cycle with stall_id=1.
  - flush_count increments in each cycle with ex_redirect=1.
  - Both saturate at all-ones; no wrap.
- Reset mid-operation: all state is cleared on the next edge and any pending stall is dropped.

Decomposition:
- hazard_pkg holds:
  - wbsel_e {WB_LOAD=0, WB_ALU=1, WB_PC=2}
  - fwdsel_e {FWD_REG=0, FWD_WB=1, FWD_MEM=2, FWD_PC=3}
  - tag_t struct
  - the tag_invalid constant
- One sub-module, fwd_pick: combinational per-operand matcher taking rs, use, ex_tag and mem_tag. It returns fwdsel, pcsel and load_hazard. hazard_ctrl instantiates it twice.

Test Plan:
- ALU chain: add x5 in ID, then add rs1=x5 next cycle -> following cycle fwdselA=10, pcselA=0, no stall.
- One gap: add x5, unrelated instruction, then sub rs2=x5 -> fwdselB=01 in sub's EX cycle.
- Load-use:
  - lw x7, then add rs1=x7 -> one cycle of stall_if=stall_id=bubble_ex=1, with fwdsel=00 in the bubble.
  - Then fwdselA=01; stall_count=1.
- PC forwarding, MEM slot: jal x1 then add rs1=x1 -> fwdselA=11, pcselA=0.
- PC forwarding, WB slot: with one gap -> fwdselA=11, pcselA=1.
- Redirect concurrent with load-use: ex_redirect=1 in the stall cycle -> flush_id=1, bubble_ex=1, stall_id=0, flush_count=1, stall_count unchanged.
- Zero register and counter saturation:
  - Producer rd=x0 with consumer rs1=x0 -> fwdselA=00.
  - stall_count preloaded near all-ones (via force) -> holds at 0xFFFFFFFF.
  - rst mid-stall -> all outputs 0 the next cycle.
